fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit synchronous FIFO. It pops bytes from the FIFO read port while the FIFO reports non-empty and serialises each byte as an 8N1 UART frame (LSB first) on a single tx line. The FIFO returns registered read data, so data is valid the cycle after the read strobe. This block accounts for that one-cycle read latency.

---
 rtl/fifo_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains the 8-bit synchronous FIFO and sends each byte as a UART frame on tx, LSB first.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       bytes_sent
);
    localparam int               IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [15:0]       baud_r, baud_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [15:0]       bytes_sent_r, bytes_sent_s;
    logic              tx_r, tx_s;
    logic              baud_last_s;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_r, par_s;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Next-state, datapath and next tx value; tx is derived from the next state so it lines up with the state register.
    always_comb begin
        state_s      = state_r;
        baud_s       = baud_r + 16'd1;
        idx_s        = idx_r;
        shift_s      = shift_r;
        bytes_sent_s = bytes_sent_r;
        tx_s         = 1'b1;
        baud_last_s  = (baud_r == BAUD_LAST);
`ifdef FIFO_UART_TX_PARITY_EN
        par_s        = par_r;
`endif
        case (state_r)
            IDLE: begin
                baud_s = 16'd0;
                if (!fifo_empty) state_s = FETCH;
                else             state_s = IDLE;
            end
            FETCH: begin
                baud_s  = 16'd0;
                state_s = LOAD;
            end
            LOAD: begin
                // Registered FIFO data became valid on the edge that ended FETCH.
                baud_s  = 16'd0;
                shift_s = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                par_s   = even_parity(fifo_dout);
`endif
                state_s = START;
            end
            START: begin
                if (baud_last_s) begin
                    baud_s  = 16'd0;
                    idx_s   = {IDX_W{1'b0}};
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (baud_last_s) begin
                    baud_s  = 16'd0;
                    shift_s = shift_r >> 1;
                    if (idx_r == IDX_LAST) begin
                        idx_s = {IDX_W{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        idx_s   = idx_r + IDX_W'(1);
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last_s) begin
                    baud_s  = 16'd0;
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (baud_last_s) begin
                    baud_s       = 16'd0;
                    bytes_sent_s = bytes_sent_r + 16'd1;
                    if (!fifo_empty) state_s = FETCH;
                    else             state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                baud_s  = 16'd0;
                state_s = IDLE;
            end
        endcase

        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_s = par_s;
`endif
            default: tx_s = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line idle at once and drops any partial byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            baud_r       <= 16'd0;
            idx_r        <= {IDX_W{1'b0}};
            shift_r      <= {DATA_W{1'b0}};
            bytes_sent_r <= 16'd0;
            tx_r         <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_r        <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            baud_r       <= baud_s;
            idx_r        <= idx_s;
            shift_r      <= shift_s;
            bytes_sent_r <= bytes_sent_s;
            tx_r         <= tx_s;
`ifdef FIFO_UART_TX_PARITY_EN
            par_r        <= par_s;
`endif
        end
    end

    assign fifo_rd    = (state_r == FETCH);
    assign busy       = (state_r != IDLE);
    assign tx         = tx_r;
    assign bytes_sent = bytes_sent_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a registered-read FIFO model and a byte scoreboard.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout  = 8'hEE;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic [15:0] bytes_sent;

    int          cyc    = 0;
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_q  [$];
    logic [15:0] sent_exp;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle from a negedge to the next; a read seen this cycle updates the FIFO model on the edge.
    task automatic tick();
        logic rd_now;
        rd_now = fifo_rd;
        @(posedge clk);
        if (rd_now === 1'b1) begin
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            else                   fifo_dout = 8'hEE;
            fifo_empty = (fifo_q.size() == 0);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic to_sb);
        fifo_q.push_back(b);
        if (to_sb) exp_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic recv_frame(input string tag, output int rd_at, output logic par_bit);
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       exp_bits [0:10];
        int         n;
        int         bad;
        int         bi;
        n = 0;
        while (fifo_rd !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, " rd"}, 32'(fifo_rd), 32'd1);
        rd_at = cyc;
        if (exp_q.size() > 0) exp_b = exp_q.pop_front();
        else                  exp_b = 8'h00;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = exp_b[i];
        exp_bits[9]  = 1'b1;
        exp_bits[10] = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        exp_bits[9]  = ^exp_b;
`endif
        got     = 8'h00;
        par_bit = 1'b1;
        bad     = 0;
        tick();
        check({tag, " gap"}, 32'({tx, fifo_rd, busy}), 32'b101);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            bi = c / CPB;
            if (tx !== exp_bits[bi] || busy !== 1'b1 || fifo_rd !== 1'b0) bad++;
            if (c % CPB == CPB / 2) begin
                if (bi >= 1 && bi <= 8) got[bi-1] = tx;
                if (bi == 9) par_bit = tx;
            end
        end
        check({tag, " shape"}, 32'(bad), 32'd0);
        check({tag, " byte"}, 32'(got), 32'(exp_b));
    endtask

    initial begin
        int   rd0, rd1, rd2;
        logic pb;
        int   rd_cnt, busy_cnt, low_cnt;

        sent_exp = 16'd0;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset rd", 32'(fifo_rd), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset count", 32'(bytes_sent), 32'd0);
        rst = 1'b0;

        rd_cnt = 0; busy_cnt = 0; low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fifo_rd !== 1'b0) rd_cnt++;
            if (busy !== 1'b0) busy_cnt++;
            if (tx !== 1'b1) low_cnt++;
        end
        check("idle rd", 32'(rd_cnt), 32'd0);
        check("idle busy", 32'(busy_cnt), 32'd0);
        check("idle tx", 32'(low_cnt), 32'd0);
        check("idle count", 32'(bytes_sent), 32'd0);

        push_byte(8'hA5, 1'b1);
        tick();
        check("a5 latency", 32'(fifo_rd), 32'd1);
        recv_frame("a5", rd0, pb);
        tick();
        sent_exp = sent_exp + 16'd1;
        check("a5 count", 32'(bytes_sent), 32'(sent_exp));
        check("a5 idle", 32'({busy, fifo_rd}), 32'b00);

        do_reset();
        sent_exp = 16'd0;
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        push_byte(8'h3C, 1'b1);
        recv_frame("b0", rd0, pb);
        tick();
        sent_exp = sent_exp + 16'd1;
        check("b0 count", 32'(bytes_sent), 32'(sent_exp));
        check("b0 refetch", 32'(fifo_rd), 32'd1);
        recv_frame("b1", rd1, pb);
        tick();
        sent_exp = sent_exp + 16'd1;
        check("b1 count", 32'(bytes_sent), 32'(sent_exp));
        check("b1 refetch", 32'(fifo_rd), 32'd1);
        recv_frame("b2", rd2, pb);
        tick();
        sent_exp = sent_exp + 16'd1;
        check("b2 count", 32'(bytes_sent), 32'd3);
        check("b2 idle", 32'({busy, fifo_rd}), 32'b00);
        check("rd spacing 01", 32'(rd1 - rd0), 32'(FRAME + 2));
        check("rd spacing 12", 32'(rd2 - rd1), 32'(FRAME + 2));
        rd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fifo_rd !== 1'b0) rd_cnt++;
        end
        check("drained no rd", 32'(rd_cnt), 32'd0);

        push_byte(8'h55, 1'b0);
        tick();
        check("55 rd", 32'(fifo_rd), 32'd1);
        repeat (2 + 4 * CPB + 1) tick();
        check("55 bit3 low", 32'(tx), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("mid rst tx", 32'(tx), 32'd1);
        check("mid rst rd", 32'(fifo_rd), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst count", 32'(bytes_sent), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sent_exp = 16'd0;
        rd_cnt = 0; busy_cnt = 0; low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fifo_rd !== 1'b0) rd_cnt++;
            if (busy !== 1'b0) busy_cnt++;
            if (tx !== 1'b1) low_cnt++;
        end
        check("post rst rd", 32'(rd_cnt), 32'd0);
        check("post rst busy", 32'(busy_cnt), 32'd0);
        check("post rst tx", 32'(low_cnt), 32'd0);

        force dut.bytes_sent_r = 16'hFFFF;
        tick();
        release dut.bytes_sent_r;
        tick();
        sent_exp = 16'hFFFF;
        check("preset", 32'(bytes_sent), 32'(sent_exp));
        push_byte(8'hC3, 1'b1);
        recv_frame("c3", rd0, pb);
        tick();
        sent_exp = sent_exp + 16'd1;
        check("wrap", 32'(bytes_sent), 32'h0000);

        push_byte(8'h07, 1'b1);
        push_byte(8'h03, 1'b1);
        recv_frame("p07", rd0, pb);
`ifdef FIFO_UART_TX_PARITY_EN
        check("p07 parity", 32'(pb), 32'd1);
`endif
        tick();
        sent_exp = sent_exp + 16'd1;
        check("p07 count", 32'(bytes_sent), 32'(sent_exp));
        recv_frame("p03", rd1, pb);
`ifdef FIFO_UART_TX_PARITY_EN
        check("p03 parity", 32'(pb), 32'd0);
`endif
        tick();
        sent_exp = sent_exp + 16'd1;
        check("p03 count", 32'(bytes_sent), 32'(sent_exp));
        check("p03 idle", 32'({busy, fifo_rd}), 32'b00);
        check("p spacing", 32'(rd1 - rd0), 32'(FRAME + 2));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
